// File: rtl/exmem_pkg.sv
// Shared types and constants for the EX/MEM boundary stage.
package exmem_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_LTZ  = 2'b11
  } br_type_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // ExcCode 12 (arithmetic overflow) placed in cause bits 6:2.
  localparam logic [31:0] EXC_OVF_CAUSE = 32'h30;

endpackage

// File: rtl/exmem_stage_branch_cond.sv
// Branch condition decode from the ALU zero/sign flags.
import exmem_pkg::*;

module branch_cond (
  input  br_type_t br_type,
  input  logic     zout,
  input  logic     minus,
  output logic     taken
);

  // Select the flag that resolves each branch type; minus only matters for bltz.
  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      BR_NONE: taken = 1'b0;
      BR_EQ:   taken = zout;
      BR_NE:   taken = ~zout;
      BR_LTZ:  taken = minus;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with branch resolution, precise overflow trap,
// EPC/cause capture, one-shot flush and a saturating overflow counter.
import exmem_pkg::*;

module exmem_stage #(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [W-1:0]     ex_pc,
  input  logic [W-1:0]     alu_sum,
  input  logic             alu_zout,
  input  logic             alu_minus,
  input  logic             alu_ovf,
  input  logic             ex_ovf_chk,
  input  logic [1:0]       ex_br_type,
  input  logic [W-1:0]     ex_br_target,
  input  logic [W-1:0]     ex_rt_data,
  input  logic [4:0]       ex_dest,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_memwrite,
  input  logic             ex_memtoreg,
  output logic             mem_valid,
  output logic [W-1:0]     mem_alu_result,
  output logic [W-1:0]     mem_store_data,
  output logic [4:0]       mem_dest,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_memtoreg,
  output logic             br_taken,
  output logic [W-1:0]     br_target,
  output logic             exc_flush,
  output logic [W-1:0]     epc,
  output logic [W-1:0]     cause,
  output logic [CNT_W-1:0] ovf_count
);

  state_t   state;
  br_type_t br_type;
  logic     cond_taken;
  logic     live;
  logic     trap;
  logic     br_hit;
  logic     en;

  assign br_type = br_type_t'(ex_br_type);

  branch_cond u_branch_cond (
    .br_type (br_type),
    .zout    (alu_zout),
    .minus   (alu_minus),
    .taken   (cond_taken)
  );

  // Squash, trap and branch qualification for the instruction sitting in EX.
  always_comb begin
    live   = ex_valid & ~br_taken & (state == RUN);
    trap   = live & ex_ovf_chk & alu_ovf;
    br_hit = live & ~trap & cond_taken;
    en     = live & ~trap & ~br_hit;
  end

  // Pipeline register, exception capture, counter and RUN/FLUSH state.
  // Pulses are cleared during stall so each stays exactly one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_dest       <= '0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_memtoreg   <= 1'b0;
      br_taken       <= 1'b0;
      br_target      <= '0;
      exc_flush      <= 1'b0;
      epc            <= '0;
      cause          <= '0;
      ovf_count      <= '0;
    end else if (stall) begin
      br_taken  <= 1'b0;
      exc_flush <= 1'b0;
    end else begin
      mem_valid      <= live & ~trap;
      mem_alu_result <= alu_sum;
      mem_store_data <= ex_rt_data;
      mem_dest       <= ex_dest;
      mem_regwrite   <= en & ex_regwrite;
      mem_memread    <= en & ex_memread;
      mem_memwrite   <= en & ex_memwrite;
      mem_memtoreg   <= en & ex_memtoreg;
      br_taken       <= br_hit;
      exc_flush      <= trap;
      if (br_hit) begin
        br_target <= ex_br_target;
      end
      if (trap) begin
        epc   <= ex_pc;
        cause <= W'(EXC_OVF_CAUSE);
        if (ovf_count != '1) begin
          ovf_count <= ovf_count + CNT_W'(1);
        end
      end
      unique case (state)
        RUN:     state <= trap ? FLUSH : RUN;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: a reference model pushes the expected
// MEM-side outputs per clock into a scoreboard queue, popped after each edge.
module tb_exmem_stage;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, stall, ex_valid;
  logic [W-1:0]  ex_pc, alu_sum, ex_br_target, ex_rt_data;
  logic          alu_zout, alu_minus, alu_ovf, ex_ovf_chk;
  logic [1:0]    ex_br_type;
  logic [4:0]    ex_dest;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic          mem_valid;
  logic [W-1:0]  mem_alu_result, mem_store_data;
  logic [4:0]    mem_dest;
  logic          mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
  logic          br_taken, exc_flush;
  logic [W-1:0]  br_target, epc, cause;
  logic [CW-1:0] ovf_count;

  always #5 clk = ~clk;

  exmem_stage #(.W(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .alu_sum(alu_sum), .alu_zout(alu_zout),
    .alu_minus(alu_minus), .alu_ovf(alu_ovf), .ex_ovf_chk(ex_ovf_chk),
    .ex_br_type(ex_br_type), .ex_br_target(ex_br_target),
    .ex_rt_data(ex_rt_data), .ex_dest(ex_dest),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_dest(mem_dest),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
    .br_taken(br_taken), .br_target(br_target), .exc_flush(exc_flush),
    .epc(epc), .cause(cause), .ovf_count(ovf_count)
  );

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  res;
    logic [W-1:0]  sd;
    logic [4:0]    dest;
    logic          rw, mr, mw, mt;
    logic          bt;
    logic [W-1:0]  bta;
    logic          fl;
    logic [W-1:0]  epc;
    logic [W-1:0]  cause;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct packed {
    logic         stall;
    logic         valid;
    logic [W-1:0] pc;
    logic [W-1:0] sum;
    logic         zout, minus, ovf, chk;
    logic [1:0]   brt;
    logic [W-1:0] tgt;
    logic [W-1:0] rt;
    logic [4:0]   dest;
    logic         rw, mr, mw, mt;
  } stim_t;

  out_t        m;
  logic        m_flush;
  out_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  function automatic out_t snap();
    out_t o;
    o.valid = mem_valid;    o.res = mem_alu_result; o.sd = mem_store_data;
    o.dest  = mem_dest;     o.rw  = mem_regwrite;   o.mr = mem_memread;
    o.mw    = mem_memwrite; o.mt  = mem_memtoreg;   o.bt = br_taken;
    o.bta   = br_target;    o.fl  = exc_flush;      o.epc = epc;
    o.cause = cause;        o.cnt = ovf_count;
    return o;
  endfunction

  // Data fields are don't-care for invalid MEM contents; branch target only
  // matters alongside a redirect pulse.
  function automatic out_t mask(input out_t x, input out_t r);
    out_t y = x;
    if (!r.valid) begin
      y.res = '0; y.sd = '0; y.dest = '0;
    end
    if (!r.bt) y.bta = '0;
    return y;
  endfunction

  task automatic model_reset();
    m       = '0;
    m_flush = 1'b0;
  endtask

  // Drive one EX slot, predict the MEM outputs after the edge, clock it.
  task automatic apply(input stim_t s);
    out_t n;
    logic live, trap, tk, hit, en;
    stall = s.stall;        ex_valid = s.valid;     ex_pc = s.pc;
    alu_sum = s.sum;        alu_zout = s.zout;      alu_minus = s.minus;
    alu_ovf = s.ovf;        ex_ovf_chk = s.chk;     ex_br_type = s.brt;
    ex_br_target = s.tgt;   ex_rt_data = s.rt;      ex_dest = s.dest;
    ex_regwrite = s.rw;     ex_memread = s.mr;      ex_memwrite = s.mw;
    ex_memtoreg = s.mt;
    n = m;
    if (!s.stall) begin
      live = s.valid & ~m.bt & ~m_flush;
      trap = live & s.chk & s.ovf;
      case (s.brt)
        2'b01:   tk = s.zout;
        2'b10:   tk = ~s.zout;
        2'b11:   tk = s.minus;
        default: tk = 1'b0;
      endcase
      hit = live & ~trap & tk;
      en  = live & ~trap & ~hit;
      n.valid = live & ~trap;
      n.res = s.sum; n.sd = s.rt; n.dest = s.dest;
      n.rw = en & s.rw; n.mr = en & s.mr; n.mw = en & s.mw; n.mt = en & s.mt;
      n.bt = hit;
      if (hit) n.bta = s.tgt;
      n.fl = trap;
      if (trap) begin
        n.epc   = s.pc;
        n.cause = 32'h30;
        if (n.cnt != 8'hFF) n.cnt = n.cnt + 8'd1;
      end
      m_flush = trap;
    end else begin
      n.bt = 1'b0;
      n.fl = 1'b0;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t alu_op(input logic [W-1:0] sum, input logic [4:0] d);
    stim_t s = '0;
    s.valid = 1'b1; s.sum = sum; s.dest = d; s.rw = 1'b1;
    s.pc = 32'h0040_0000 + sum; s.rt = ~sum;
    return s;
  endfunction

  task automatic test_reset();
    out_t e, o;
    stim_t s;
    reset = 1'b1;
    model_reset();
    apply('0);
    void'(sb.pop_front());
    n_cmp++;
    if (snap() !== out_t'('0)) begin
      n_mis++; $display("FAIL reset_init got=%h exp=0", snap());
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = alu_op(32'h1000 + 32'(i), 5'(i + 1));
      if (i == 2) begin s.chk = 1'b1; s.ovf = 1'b1; end
      apply(s);
      e = sb.pop_front(); o = mask(snap(), e); e = mask(e, e);
      n_cmp++;
      if (o !== e) begin
        n_mis++; $display("FAIL reset_seq[%0d] got=%h exp=%h", i, o, e);
      end
      // Asynchronous reset with MEM valid (i=1) and mid-FLUSH (i=2).
      if (i == 1 || i == 2) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (snap() !== out_t'('0)) begin
          n_mis++; $display("FAIL reset_async[%0d] got=%h exp=0", i, snap());
        end
        @(posedge clk);
        #1 reset = 1'b0;
      end
    end
    apply('0);
    e = sb.pop_front(); o = mask(snap(), e); e = mask(e, e);
    n_cmp++;
    if (o !== e || br_taken !== 1'b0 || exc_flush !== 1'b0) begin
      n_mis++; $display("FAIL reset_nopulse got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_trap();
    out_t e, o;
    stim_t s [3];
    s[0] = alu_op(32'h7FFF_FFFF, 5'd9);
    s[0].chk = 1'b1; s[0].ovf = 1'b1; s[0].pc = 32'h0040_0010;
    s[1] = alu_op(32'h0000_0055, 5'd10);
    s[2] = alu_op(32'h0000_0066, 5'd11);
    s[2].chk = 1'b0; s[2].ovf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      e = sb.pop_front(); o = mask(snap(), e); e = mask(e, e);
      n_cmp++;
      if (o !== e) begin
        n_mis++; $display("FAIL trap_seq[%0d] got=%h exp=%h", i, o, e);
      end
      if (i == 0) begin
        n_cmp++;
        if ({exc_flush, epc, cause, mem_valid, mem_regwrite, ovf_count} !==
            {1'b1, 32'h0040_0010, 32'h30, 1'b0, 1'b0, 8'd1}) begin
          n_mis++;
          $display("FAIL trap_capture got fl=%b epc=%h cause=%h v=%b rw=%b cnt=%0d exp fl=1 epc=00400010 cause=30 v=0 rw=0 cnt=1",
                   exc_flush, epc, cause, mem_valid, mem_regwrite, ovf_count);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if ({mem_valid, mem_regwrite, exc_flush} !== 3'b000) begin
          n_mis++; $display("FAIL trap_squash got=%b exp=000", {mem_valid, mem_regwrite, exc_flush});
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({mem_valid, mem_regwrite, exc_flush, ovf_count} !== {3'b110, 8'd1}) begin
          n_mis++; $display("FAIL trap_unchecked_ovf got v=%b rw=%b fl=%b cnt=%0d exp v=1 rw=1 fl=0 cnt=1",
                            mem_valid, mem_regwrite, exc_flush, ovf_count);
        end
      end
    end
  endtask

  task automatic test_branch();
    out_t e, o;
    stim_t s [8];
    s[0] = alu_op(32'h0, 5'd0); s[0].brt = 2'b01; s[0].zout = 1'b1;
    s[0].tgt = 32'h0040_0100; s[0].rw = 1'b0;
    s[1] = alu_op(32'h0000_0077, 5'd12);
    s[2] = alu_op(32'h0000_0088, 5'd13);
    s[3] = alu_op(32'h5, 5'd0); s[3].brt = 2'b11; s[3].zout = 1'b1; s[3].minus = 1'b0;
    s[3].tgt = 32'h0040_0200; s[3].rw = 1'b0;
    s[4] = alu_op(32'h3, 5'd0); s[4].brt = 2'b10; s[4].zout = 1'b0;
    s[4].tgt = 32'h0040_0300; s[4].rw = 1'b0;
    s[5] = alu_op(32'h0000_0099, 5'd14);
    s[6] = alu_op(32'h0, 5'd0); s[6].brt = 2'b01; s[6].zout = 1'b1;
    s[6].chk = 1'b1; s[6].ovf = 1'b1; s[6].tgt = 32'h0040_0400;
    s[7] = alu_op(32'h0000_00AA, 5'd15);
    for (int i = 0; i < 8; i++) begin
      apply(s[i]);
      e = sb.pop_front(); o = mask(snap(), e); e = mask(e, e);
      n_cmp++;
      if (o !== e) begin
        n_mis++; $display("FAIL branch_seq[%0d] got=%h exp=%h", i, o, e);
      end
      if (i == 0) begin
        n_cmp++;
        if ({br_taken, br_target, mem_valid, mem_regwrite} !== {1'b1, 32'h0040_0100, 1'b1, 1'b0}) begin
          n_mis++; $display("FAIL beq_taken got bt=%b tgt=%h v=%b exp bt=1 tgt=00400100 v=1", br_taken, br_target, mem_valid);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if ({br_taken, mem_valid} !== 2'b00) begin
          n_mis++; $display("FAIL beq_shadow got bt=%b v=%b exp 00", br_taken, mem_valid);
        end
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (br_taken !== (i == 4)) begin
          n_mis++; $display("FAIL %s got=%b exp=%b", (i == 3) ? "bltz_not" : "bne_taken", br_taken, i == 4);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({br_taken, exc_flush} !== 2'b01) begin
          n_mis++; $display("FAIL trap_over_branch got bt=%b fl=%b exp bt=0 fl=1", br_taken, exc_flush);
        end
      end
    end
  endtask

  task automatic test_stall();
    out_t e, o;
    stim_t s [9];
    s[0] = '0; s[0].valid = 1'b1; s[0].sum = 32'h1000_0004; s[0].dest = 5'd8;
    s[0].rw = 1'b1; s[0].mr = 1'b1; s[0].mt = 1'b1; s[0].pc = 32'h0040_0500;
    for (int i = 1; i <= 3; i++) begin
      s[i] = alu_op(32'hDEAD_0000 + 32'(i), 5'd20);
      s[i].stall = 1'b1; s[i].chk = 1'b1; s[i].ovf = 1'b1;
    end
    s[4] = alu_op(32'h0, 5'd0); s[4].brt = 2'b01; s[4].zout = 1'b1;
    s[4].tgt = 32'h0040_0600; s[4].rw = 1'b0;
    s[5] = alu_op(32'h1111, 5'd21); s[5].stall = 1'b1;
    s[6] = alu_op(32'h2222, 5'd22); s[6].stall = 1'b1;
    s[7] = alu_op(32'h3333, 5'd23);
    s[8] = alu_op(32'h4444, 5'd24);
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      e = sb.pop_front(); o = mask(snap(), e); e = mask(e, e);
      n_cmp++;
      if (o !== e) begin
        n_mis++; $display("FAIL stall_seq[%0d] got=%h exp=%h", i, o, e);
      end
      if (i >= 1 && i <= 3) begin
        n_cmp++;
        if ({mem_valid, mem_alu_result, mem_dest, mem_memread, br_taken, exc_flush} !==
            {1'b1, 32'h1000_0004, 5'd8, 1'b1, 1'b0, 1'b0}) begin
          n_mis++; $display("FAIL stall_hold[%0d] got v=%b res=%h d=%0d mr=%b bt=%b fl=%b exp v=1 res=10000004 d=8 mr=1 bt=0 fl=0",
                            i, mem_valid, mem_alu_result, mem_dest, mem_memread, br_taken, exc_flush);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if ({br_taken, mem_valid, mem_regwrite} !== 3'b010) begin
          n_mis++; $display("FAIL stall_pulse got bt=%b v=%b rw=%b exp bt=0 v=1 rw=0", br_taken, mem_valid, mem_regwrite);
        end
      end
    end
  endtask

  task automatic test_saturation();
    out_t e, o;
    stim_t t, b;
    int unsigned bad = 0;
    t = alu_op(32'h8000_0000, 5'd3); t.chk = 1'b1; t.ovf = 1'b1;
    b = alu_op(32'h0000_0001, 5'd4);
    for (int i = 0; i < 600; i++) begin
      t.pc = 32'h0040_1000 + 32'(i * 4);
      apply((i % 2 == 0) ? t : b);
      e = sb.pop_front(); o = mask(snap(), e); e = mask(e, e);
      n_cmp++;
      if (o !== e) begin
        n_mis++; bad++;
        if (bad <= 5) $display("FAIL sat_seq[%0d] got=%h exp=%h", i, o, e);
      end
    end
    n_cmp++;
    if (ovf_count !== 8'hFF) begin
      n_mis++; $display("FAIL sat_count got=%0d exp=255", ovf_count);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_pc = '0; alu_sum = '0;
    alu_zout = 1'b0; alu_minus = 1'b0; alu_ovf = 1'b0; ex_ovf_chk = 1'b0;
    ex_br_type = 2'b00; ex_br_target = '0; ex_rt_data = '0; ex_dest = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0; ex_memtoreg = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_trap();
    test_branch();
    test_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
